// File: rtl/genesis_pad_pkg.sv
// Shared definitions for the Genesis pad responder: button indices, phase type
// and the phase-to-pin map, also used by the pad-reader bench model.
package genesis_pad_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 75000;

  typedef logic [2:0] phase_t;

  // Result is {P1,P2,P3,P4,P6,P9}, active-low; literal 0/1 entries are pin levels.
  function automatic logic [5:0] pad_pins(input phase_t phase, input logic [11:0] btn);
    logic [5:0] p;
    case (phase)
      3'd0, 3'd2, 3'd4:
        p = ~{btn[BTN_UP], btn[BTN_DOWN], btn[BTN_LEFT], btn[BTN_RIGHT], btn[BTN_B], btn[BTN_C]};
      3'd1, 3'd3:
        p = {~btn[BTN_UP], ~btn[BTN_DOWN], 2'b00, ~btn[BTN_A], ~btn[BTN_START]};
      3'd5:
        p = {4'b0000, ~btn[BTN_A], ~btn[BTN_START]};
      3'd6:
        p = ~{btn[BTN_Z], btn[BTN_Y], btn[BTN_X], btn[BTN_MODE], btn[BTN_B], btn[BTN_C]};
      default:
        p = {4'b1111, ~btn[BTN_A], ~btn[BTN_START]};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/genesis_pad_responder_sync.sv
// Select synchroniser with registered edge flag; sel_s and sel_edge are
// aligned so sel_s already holds the new level when sel_edge is high.
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sel_s,
  output logic sel_edge
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain    <= {STAGES{RESET_VAL}};
      sel_s    <= RESET_VAL;
      sel_edge <= 1'b0;
    end else begin
      chain    <= {chain[STAGES-2:0], async_in};
      sel_s    <= chain[STAGES-1];
      sel_edge <= chain[STAGES-1] ^ sel_s;
    end
  end

endmodule

// File: rtl/genesis_pad_responder.sv
// Sega Genesis pad emulator, DB9 side. Define GENESIS_SIX_BUTTON_EN for the
// 8-phase 6-button pad; otherwise a plain 3-button pad is built.
module genesis_pad_responder
  import genesis_pad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        Select,
  input  logic [11:0] Botoes,
  output logic        Pino1,
  output logic        Pino2,
  output logic        Pino3,
  output logic        Pino4,
  output logic        Pino6,
  output logic        Pino9,
  output logic [2:0]  Fase
);

  logic       sel_s;
  logic       sel_edge;
  phase_t     phase;
  logic [5:0] pins;

  sync_edge_detect #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk      (Clock50),
    .reset    (Reset),
    .async_in (Select),
    .sel_s    (sel_s),
    .sel_edge (sel_edge)
  );

`ifdef GENESIS_SIX_BUTTON_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // A long quiet Select means the console restarted its read; realign to the 3-button phases.
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      phase    <= '0;
      idle_cnt <= '0;
    end else if (sel_edge) begin
      phase    <= phase + 3'd1;
      idle_cnt <= '0;
    end else if (idle_cnt == IDLE_LAST) begin
      phase    <= {2'b00, ~sel_s};
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge Clock50) begin
    if (Reset) begin
      phase <= '0;
    end else if (sel_edge) begin
      phase <= {2'b00, ~sel_s};
    end
  end
`endif

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      pins <= '1;
    end else begin
      pins <= pad_pins(phase, Botoes);
    end
  end

  assign {Pino1, Pino2, Pino3, Pino4, Pino6, Pino9} = pins;
  assign Fase = phase;

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Directed bench for genesis_pad_responder; scenarios follow GENESIS_SIX_BUTTON_EN.
module tb_genesis_pad_responder;

  logic        Clock50 = 1'b0;
  logic        Reset   = 1'b1;
  logic        Select  = 1'b1;
  logic [11:0] Botoes  = 12'h000;
  logic        Pino1, Pino2, Pino3, Pino4, Pino6, Pino9;
  logic [2:0]  Fase;

  int total = 0;
  int bad   = 0;

  genesis_pad_responder dut (
    .Clock50 (Clock50),
    .Reset   (Reset),
    .Select  (Select),
    .Botoes  (Botoes),
    .Pino1   (Pino1),
    .Pino2   (Pino2),
    .Pino3   (Pino3),
    .Pino4   (Pino4),
    .Pino6   (Pino6),
    .Pino9   (Pino9),
    .Fase    (Fase)
  );

  always #10 Clock50 = ~Clock50;

  wire [5:0] pins = {Pino1, Pino2, Pino3, Pino4, Pino6, Pino9};

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock50);
  endtask

  task automatic do_reset;
    @(negedge Clock50);
    Reset = 1'b1;
    wait_cycles(3);
    Reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset;
    Botoes = 12'h000;
    Select = 1'b1;
    @(negedge Clock50);
    Reset = 1'b1;
    wait_cycles(3);
    total++;
    if (pins !== 6'b111111) begin
      bad++;
      $display("[TB] FAIL reset_pins_during: got %b want %b", pins, 6'b111111);
    end
    total++;
    if (Fase !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_fase_during: got %0d want 0", Fase);
    end
    Reset = 1'b0;
    wait_cycles(8);
    total++;
    if (pins !== 6'b111111) begin
      bad++;
      $display("[TB] FAIL reset_pins_after: got %b want %b", pins, 6'b111111);
    end
    total++;
    if (Fase !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_fase_after: got %0d want 0", Fase);
    end
  endtask

  task automatic test_map;
    logic [11:0] btn_tab [3] = '{12'h0A1, 12'h054, 12'hF00};
    logic [5:0]  hi_tab  [3] = '{6'b011101, 6'b110110, 6'b111111};
    logic [5:0]  lo_tab  [3] = '{6'b010010, 6'b110001, 6'b110011};
    for (int i = 0; i < 3; i++) begin
      Select = 1'b1;
      Botoes = btn_tab[i];
      do_reset();
      wait_cycles(8);
      total++;
      if (pins !== hi_tab[i]) begin
        bad++;
        $display("[TB] FAIL map_hi[%0d]: got %b want %b", i, pins, hi_tab[i]);
      end
      total++;
      if (Fase !== 3'd0) begin
        bad++;
        $display("[TB] FAIL map_hi_fase[%0d]: got %0d want 0", i, Fase);
      end
      Select = 1'b0;
      wait_cycles(10);
      total++;
      if (pins !== lo_tab[i]) begin
        bad++;
        $display("[TB] FAIL map_lo[%0d]: got %b want %b", i, pins, lo_tab[i]);
      end
      total++;
      if (Fase !== 3'd1) begin
        bad++;
        $display("[TB] FAIL map_lo_fase[%0d]: got %0d want 1", i, Fase);
      end
      Select = 1'b1;
      wait_cycles(10);
    end
  endtask

  task automatic test_button_latency;
    Select = 1'b1;
    Botoes = 12'h000;
    do_reset();
    wait_cycles(8);
    Botoes = 12'h001;
    #1;
    total++;
    if (pins !== 6'b111111) begin
      bad++;
      $display("[TB] FAIL btn_latency_early: got %b want %b", pins, 6'b111111);
    end
    @(negedge Clock50);
    total++;
    if (pins !== 6'b011111) begin
      bad++;
      $display("[TB] FAIL btn_latency_one: got %b want %b", pins, 6'b011111);
    end
  endtask

`ifdef GENESIS_SIX_BUTTON_EN
  task automatic test_six_phases;
    logic [5:0] lo_exp [4] = '{6'b110011, 6'b110011, 6'b000011, 6'b111111};
    logic [5:0] hi_exp [4] = '{6'b111111, 6'b111111, 6'b110011, 6'b111111};
    logic [2:0] ph;
    Select = 1'b1;
    Botoes = 12'h900;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      Select = 1'b0;
      wait_cycles(100);
      ph = 3'(2 * p + 1);
      total++;
      if (Fase !== ph) begin
        bad++;
        $display("[TB] FAIL six_lo_fase[%0d]: got %0d want %0d", p, Fase, ph);
      end
      total++;
      if (pins !== lo_exp[p]) begin
        bad++;
        $display("[TB] FAIL six_lo_pins[%0d]: got %b want %b", p, pins, lo_exp[p]);
      end
      Select = 1'b1;
      wait_cycles(100);
      ph = 3'(2 * p + 2);
      total++;
      if (Fase !== ph) begin
        bad++;
        $display("[TB] FAIL six_hi_fase[%0d]: got %0d want %0d", p, Fase, ph);
      end
      total++;
      if (pins !== hi_exp[p]) begin
        bad++;
        $display("[TB] FAIL six_hi_pins[%0d]: got %b want %b", p, pins, hi_exp[p]);
      end
    end
  endtask

  task automatic test_timeout;
    Select = 1'b1;
    Botoes = 12'h900;
    do_reset();
    Select = 1'b0;
    wait_cycles(20);
    Select = 1'b1;
    wait_cycles(20);
    Select = 1'b0;
    wait_cycles(20);
    total++;
    if (Fase !== 3'd3) begin
      bad++;
      $display("[TB] FAIL timeout_start: got %0d want 3", Fase);
    end
    Select = 1'b1;
    wait_cycles(20);
    total++;
    if (Fase !== 3'd4) begin
      bad++;
      $display("[TB] FAIL timeout_rise: got %0d want 4", Fase);
    end
    wait_cycles(74000);
    total++;
    if (Fase !== 3'd4) begin
      bad++;
      $display("[TB] FAIL timeout_early: got %0d want 4", Fase);
    end
    wait_cycles(1100);
    total++;
    if (Fase !== 3'd0) begin
      bad++;
      $display("[TB] FAIL timeout_resync: got %0d want 0", Fase);
    end
    Select = 1'b0;
    wait_cycles(20);
    total++;
    if (Fase !== 3'd1) begin
      bad++;
      $display("[TB] FAIL timeout_next_fase: got %0d want 1", Fase);
    end
    total++;
    if (pins !== 6'b110011) begin
      bad++;
      $display("[TB] FAIL timeout_next_pins: got %b want %b", pins, 6'b110011);
    end
    Select = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_reset_mid;
    Select = 1'b1;
    Botoes = 12'h0A1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      Select = 1'b0;
      wait_cycles(20);
      Select = 1'b1;
      wait_cycles(20);
    end
    total++;
    if (Fase !== 3'd6) begin
      bad++;
      $display("[TB] FAIL mid_reset_pre: got %0d want 6", Fase);
    end
    total++;
    if (pins !== 6'b111101) begin
      bad++;
      $display("[TB] FAIL mid_reset_pre_pins: got %b want %b", pins, 6'b111101);
    end
    Reset = 1'b1;
    wait_cycles(3);
    total++;
    if (pins !== 6'b111111) begin
      bad++;
      $display("[TB] FAIL mid_reset_pins: got %b want %b", pins, 6'b111111);
    end
    total++;
    if (Fase !== 3'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset_fase: got %0d want 0", Fase);
    end
    Reset = 1'b0;
    wait_cycles(10);
    total++;
    if (Fase !== 3'd0) begin
      bad++;
      $display("[TB] FAIL mid_after_fase: got %0d want 0", Fase);
    end
    total++;
    if (pins !== 6'b011101) begin
      bad++;
      $display("[TB] FAIL mid_after_pins: got %b want %b", pins, 6'b011101);
    end
    Select = 1'b0;
    wait_cycles(10);
    total++;
    if (Fase !== 3'd1) begin
      bad++;
      $display("[TB] FAIL mid_fall_fase: got %0d want 1", Fase);
    end
    total++;
    if (pins !== 6'b010010) begin
      bad++;
      $display("[TB] FAIL mid_fall_pins: got %b want %b", pins, 6'b010010);
    end
    Select = 1'b1;
    wait_cycles(10);
  endtask
`else
  task automatic test_three_button;
    Select = 1'b1;
    Botoes = 12'h900;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      Select = 1'b0;
      wait_cycles(100);
      total++;
      if (pins !== 6'b110011) begin
        bad++;
        $display("[TB] FAIL three_lo_pins[%0d]: got %b want %b", p, pins, 6'b110011);
      end
      total++;
      if (Fase !== 3'd1) begin
        bad++;
        $display("[TB] FAIL three_lo_fase[%0d]: got %0d want 1", p, Fase);
      end
      Select = 1'b1;
      wait_cycles(100);
      total++;
      if (pins !== 6'b111111) begin
        bad++;
        $display("[TB] FAIL three_hi_pins[%0d]: got %b want %b", p, pins, 6'b111111);
      end
      total++;
      if (Fase !== 3'd0) begin
        bad++;
        $display("[TB] FAIL three_hi_fase[%0d]: got %0d want 0", p, Fase);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_map();
    test_button_latency();
`ifdef GENESIS_SIX_BUTTON_EN
    test_six_phases();
    test_timeout();
    test_reset_mid();
`else
    test_three_button();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
